// File: rtl/zigzag_sweep_counter_pkg.sv
// rtl/zigzag_sweep_counter_pkg.sv - shared phase encodings and MAX helper for the zig-zag sweep counter
package zigzag_sweep_counter_pkg;

    localparam logic PH_ZIGZAG  = 1'b0;
    localparam logic PH_DESCENT = 1'b1;

    function automatic int unsigned max_from_width(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/zigzag_sweep_counter_if.sv
// rtl/zigzag_sweep_counter_if.sv - control/status bundle of the zig-zag sweep counter
interface zigzag_sweep_counter_if #(
    parameter int WIDTH = 6
);
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] out;
    logic             phase;
    logic [WIDTH:0]   step;
    logic             done;

    modport master (
        output en,
        output clr,
        input  out,
        input  phase,
        input  step,
        input  done
    );

    modport slave (
        input  en,
        input  clr,
        output out,
        output phase,
        output step,
        output done
    );
endinterface

// File: rtl/zigzag_sweep_counter_step_alu.sv
// rtl/zigzag_sweep_counter_step_alu.sv - combinational next value/step/phase of the zig-zag sweep
module zigzag_step_alu
    import zigzag_sweep_counter_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] i_out,
    input  logic             i_phase,
    input  logic [WIDTH:0]   i_step,
    output logic [WIDTH-1:0] o_out,
    output logic             o_phase,
    output logic [WIDTH:0]   o_step,
    output logic             o_wrap
);

    localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(max_from_width(WIDTH));
    localparam logic [WIDTH:0] ONE_W = (WIDTH+1)'(1);

    // All arithmetic is one bit wider than out so k = 2^WIDTH and out+k never wrap.
    logic [WIDTH:0] w_cur;
    logic [WIDTH:0] w_k;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_d;
    logic [WIDTH:0] w_nxt;

    assign w_cur = {1'b0, i_out};
    assign w_k   = i_step + ONE_W;
    assign w_sum = w_cur + w_k;
    assign w_d   = ONE_W << i_step;

    always_comb begin
        w_nxt   = w_cur;
        o_phase = i_phase;
        o_step  = i_step;
        o_wrap  = 1'b0;
        if (i_phase == PH_ZIGZAG) begin
            if (w_cur > w_k) begin
                w_nxt = w_cur - w_k;
            end else if (w_sum > MAX_W) begin
                w_nxt = MAX_W;
            end else begin
                w_nxt = w_sum;
            end
            if (w_nxt == MAX_W) begin
                o_phase = PH_DESCENT;
                o_step  = '0;
            end else begin
                o_step  = w_k;
            end
        end else begin
            if (w_cur >= w_d) begin
                w_nxt = w_cur - w_d;
            end else begin
                w_nxt = '0;
            end
            if (w_nxt == '0) begin
                o_phase = PH_ZIGZAG;
                o_step  = '0;
                o_wrap  = 1'b1;
            end else begin
                o_step  = i_step + ONE_W;
            end
        end
        o_out = w_nxt[WIDTH-1:0];
    end

endmodule

// File: rtl/zigzag_sweep_counter.sv
// rtl/zigzag_sweep_counter.sv - two-phase zig-zag / binary-descent sweep counter; ZIGZAG_ONESHOT_EN parks after one sweep
module zigzag_sweep_counter
    import zigzag_sweep_counter_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    zigzag_sweep_counter_if.slave  bus
);

    logic [WIDTH-1:0] r_out;
    logic             r_phase;
    logic [WIDTH:0]   r_step;
    logic             r_done;

    logic [WIDTH-1:0] w_nxt_out;
    logic             w_nxt_phase;
    logic [WIDTH:0]   w_nxt_step;
    logic             w_wrap;
    logic             w_adv;

    zigzag_step_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_out   (r_out),
        .i_phase (r_phase),
        .i_step  (r_step),
        .o_out   (w_nxt_out),
        .o_phase (w_nxt_phase),
        .o_step  (w_nxt_step),
        .o_wrap  (w_wrap)
    );

`ifdef ZIGZAG_ONESHOT_EN
    logic r_parked;

    assign w_adv = bus.en & ~r_parked;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parked <= 1'b0;
        end else if (bus.clr) begin
            r_parked <= 1'b0;
        end else if (w_adv && w_wrap) begin
            r_parked <= 1'b1;
        end
    end
`else
    assign w_adv = bus.en;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out   <= '0;
            r_phase <= PH_ZIGZAG;
            r_step  <= '0;
            r_done  <= 1'b0;
        end else if (bus.clr) begin
            r_out   <= '0;
            r_phase <= PH_ZIGZAG;
            r_step  <= '0;
            r_done  <= 1'b0;
        end else begin
            // done is a single-cycle pulse alongside out returning to 0
            r_done <= w_adv & w_wrap;
            if (w_adv) begin
                r_out   <= w_nxt_out;
                r_phase <= w_nxt_phase;
                r_step  <= w_nxt_step;
            end
        end
    end

    assign bus.out   = r_out;
    assign bus.phase = r_phase;
    assign bus.step  = r_step;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_zigzag_sweep_counter.sv
// tb/tb_zigzag_sweep_counter.sv - directed bench for zig-zag sweep counter at WIDTH 6 and 4
module tb_zigzag_sweep_counter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    zigzag_sweep_counter_if #(.WIDTH(6)) if6 ();
    zigzag_sweep_counter_if #(.WIDTH(4)) if4 ();

    zigzag_sweep_counter #(.WIDTH(6)) u_dut6 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if6)
    );

    zigzag_sweep_counter #(.WIDTH(4)) u_dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if4)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk6(input string tag, input int o, input int p, input int s, input int d);
        chk({tag, ".out6"},   int'(if6.out),   o);
        chk({tag, ".phase6"}, int'(if6.phase), p);
        chk({tag, ".step6"},  int'(if6.step),  s);
        chk({tag, ".done6"},  int'(if6.done),  d);
    endtask

    task automatic chk4(input string tag, input int o, input int p, input int s, input int d);
        chk({tag, ".out4"},   int'(if4.out),   o);
        chk({tag, ".phase4"}, int'(if4.phase), p);
        chk({tag, ".step4"},  int'(if4.step),  s);
        chk({tag, ".done4"},  int'(if4.done),  d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a6[10];
        int d6[6];
        int a4[12];
        int p4[12];
        int s4[12];
        a6 = '{1, 3, 6, 2, 7, 1, 8, 16, 7, 17};
        d6 = '{62, 60, 56, 48, 32, 0};
        a4 = '{1, 3, 6, 2, 7, 1, 8, 15, 14, 12, 8, 0};
        p4 = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        s4 = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 0};

        rst_n   = 1'b0;
        if6.en  = 1'b1;
        if6.clr = 1'b0;
        if4.en  = 1'b1;
        if4.clr = 1'b0;
        repeat (5) begin
            tick();
            chk6("reset", 0, 0, 0, 0);
            chk4("reset", 0, 0, 0, 0);
        end
        rst_n  = 1'b1;
        if4.en = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk6($sformatf("w6_start%0d", i + 1), a6[i], 0, i + 1, 0);
        end

        if6.en = 1'b0;
        repeat (10) tick();
        chk6("hold", 17, 0, 10, 0);
        if6.en = 1'b1;
        tick();
        chk6("resume", 6, 0, 11, 0);

        repeat (45) tick();
        chk6("edge56", 6, 0, 56, 0);
        tick();
        chk6("edge57", 63, 1, 0, 0);
        tick();
        chk6("edge58", 62, 1, 1, 0);
        tick();
        chk6("edge59", 60, 1, 2, 0);
        tick();
        chk6("edge60", 56, 1, 3, 0);

        if6.clr = 1'b1;
        tick();
        chk6("clr", 0, 0, 0, 0);
        if6.clr = 1'b0;
        tick();
        chk6("after_clr", 1, 0, 1, 0);

        repeat (55) tick();
        chk6("sweep_edge56", 6, 0, 56, 0);
        tick();
        chk6("sweep_edge57", 63, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 5) chk6($sformatf("descent%0d", i), d6[i], 1, i + 1, 0);
            else       chk6("descent_end", 0, 0, 0, 1);
        end
        tick();
`ifdef ZIGZAG_ONESHOT_EN
        chk6("edge64", 0, 0, 0, 0);
`else
        chk6("edge64", 1, 0, 1, 0);
`endif
        if6.en = 1'b0;

        if4.en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk4($sformatf("w4_edge%0d", i + 1), a4[i], p4[i], s4[i], (i == 11) ? 1 : 0);
        end
`ifdef ZIGZAG_ONESHOT_EN
        repeat (20) begin
            tick();
            chk4("parked", 0, 0, 0, 0);
        end
        if4.clr = 1'b1;
        tick();
        chk4("park_clr", 0, 0, 0, 0);
        if4.clr = 1'b0;
        tick();
        chk4("park_restart", 1, 0, 1, 0);
`else
        tick();
        chk4("w4_edge13", 1, 0, 1, 0);
`endif

        tick();
        chk4("pre_async", 3, 0, 2, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk4("async_rst", 0, 0, 0, 0);
        chk6("async_rst", 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
